fp_mult_stream: RTL and testbench
=================================

# fp_mult_stream

Pipelined fixed-point multiplier with valid/ready handshaking on both sides, a configurable pipeline depth, signed or unsigned operands, and selectable rounding. It sits between Calyx-generated datapath stages that need a fully back-pressurable multiplier. It accepts one operand pair per cycle and returns results in issue order. An overflow flag accompanies every result, and saturation is optional.

## Interface
- WIDTH, 32, operand and result width in bits
- INT_WIDTH, 16, integer bits of each operand and of the result
- FRAC_WIDTH, 16, fraction bits; WIDTH must equal INT_WIDTH + FRAC_WIDTH
- SIGNED, 0, 1 = two's-complement operands and result; 0 = unsigned
- STAGES, 3, pipeline depth in register stages, ≥ 2
- ROUND, 0, 0 = truncate discarded fraction bits; 1 = round half up
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept the pair this cycle
- left  in  WIDTH  operand A
- right  in  WIDTH  operand B
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result this cycle
- out  out  WIDTH  product, in the same Q format as the operands
- ovf  out  1  result integer part exceeded the representable range

## Operation
- Global enable `adv = ~out_valid | out_ready`. All stage registers, data and valid bits, load only when `adv` = 1. Otherwise everything holds.
- `in_ready = adv`. A transfer occurs when `in_valid & in_ready`. A bubble (valid = 0) enters stage 1 when `in_valid` = 0.
- Stage 1 registers the operands.
- Stage 2 forms the full 2·WIDTH product: sign-extended when SIGNED = 1, zero-extended otherwise.
- Stages 3..STAGES are delay registers.
- Rounding and overflow are computed combinationally from the final stage.
- Rounding:
  - ROUND = 1 adds 2^(FRAC_WIDTH-1) to the 2·WIDTH product before the slice.
  - The add is performed at 2·WIDTH+1 bits, so the carry is kept.
- Result slice: product bits [FRAC_WIDTH+WIDTH-1 : FRAC_WIDTH].
- ovf = 1 when the bits above the slice are not all zeros (unsigned) or not a sign extension of the slice MSB (signed).
- The rounding carry counts toward ovf.
- `out`/`ovf` are stable while `out_valid & ~out_ready`.
- Results leave in acceptance order; no reordering and no drops.

## Timing
- Latency is exactly STAGES cycles from the accepting edge to `out_valid` when no stall occurs. Every cycle with `adv` = 0 adds one cycle.
- Throughput is 1 result per cycle when `out_ready` stays high.
- Stall: with `out_valid` = 1 and `out_ready` = 0, `in_ready` = 0 in the same cycle (combinational from out_ready).
- A full pipeline holds STAGES results without loss.
- Simultaneous output accept and input accept in one cycle is legal. The pipeline shifts by one.
- Reset:
  - All valid bits, data registers, `out` and `ovf` go to 0 on the next edge.
  - `out_valid` = 0 and `in_ready` = 1 after reset.
  - Reset mid-operation discards in-flight operands; no result emerges for them.
- Inputs `left`/`right` are sampled only on an accepting edge. Changes at other times have no effect.

## Configuration
- `FP_MULT_STREAM_SAT_EN` defined:
  - When ovf = 1, `out` is clamped.
  - Unsigned clamps to all-ones.
  - Signed clamps to 0x7F…F for a positive true product and 0x80…0 for a negative one. The sign is taken from the MSB of the 2·WIDTH product.
  - ovf is still asserted.
- Not defined: `out` is the wrapped slice and ovf is informational only. No saturation logic is synthesised.

## Test plan
- Defaults, left = 0x00018000, right = 0x00020000, out_ready = 1 -> out = 0x00030000, ovf = 0, out_valid exactly 3 cycles after acceptance.
- SIGNED = 1, left = 0xFFFE8000 (−1.5), right = 0x00020000 -> out = 0xFFFD0000, ovf = 0.
- left = 0x00000001, right = 0x00008000 -> ROUND = 0: out = 0x00000000; ROUND = 1: out = 0x00000001.
- SIGNED = 1, left = 0x7FFF0000, right = 0x00020000:
  - without the macro: ovf = 1, out = 0xFFFE0000
  - with FP_MULT_STREAM_SAT_EN: out = 0x7FFFFFFF, ovf = 1
- Back-to-back issue of 1..6 (×0x00010000) with out_ready low for cycles 4–8:
  - in_ready drops once 3 results are held
  - outputs arrive as 1..6 in order, none lost or duplicated
  - out stays stable while stalled
- Issue 2 pairs, assert reset for one cycle before either emerges -> out_valid stays 0, out = 0, in_ready = 1 after reset, the next issued pair yields its correct result.

Source files
------------

// File: rtl/fp_mult_stream_if.sv
// Valid/ready operand and result channels for fp_mult_stream.
// The producer/consumer side uses the master modport; the multiplier uses slave.
interface fp_mult_stream_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             ovf;

    modport master (
        output in_valid, left, right, out_ready,
        input  in_ready, out_valid, out, ovf
    );

    modport slave (
        input  in_valid, left, right, out_ready,
        output in_ready, out_valid, out, ovf
    );
endinterface

// File: rtl/fp_mult_stream.sv
// Back-pressurable pipelined fixed-point multiplier with overflow flag.
// Define FP_MULT_STREAM_SAT_EN to clamp the result whenever ovf is raised.
module fp_mult_stream #(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16,
    parameter int SIGNED     = 0,
    parameter int STAGES     = 3,
    parameter int ROUND      = 0
) (
    input logic              clk,
    input logic              reset,
    fp_mult_stream_if.slave  bus
);

    localparam int PW = 2 * WIDTH;
    localparam int UW = PW - FRAC_WIDTH - WIDTH + 1;
    localparam logic [PW:0] ROUND_ADD =
        (ROUND != 0) ? ((PW + 1)'(1) << (FRAC_WIDTH - 1)) : '0;

    logic              adv;
    logic [STAGES:1]   valid_q;
    logic [WIDTH-1:0]  left_q;
    logic [WIDTH-1:0]  right_q;
    logic [PW-1:0]     prod_q [2:STAGES];
    logic [PW-1:0]     left_ext;
    logic [PW-1:0]     right_ext;
    logic [PW-1:0]     prod_full;
    logic              sign_ext;
    logic [PW:0]       rounded;
    logic [WIDTH-1:0]  slice;
    logic [UW-1:0]     upper;
    logic              ovf_c;
    logic [WIDTH-1:0]  out_c;
    logic              unused_frac;

    // One shared enable: a stalled head freezes every stage, bubbles included.
    assign adv           = ~valid_q[STAGES] | bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = valid_q[STAGES];

    always_comb begin
        left_ext  = (SIGNED != 0) ? {{WIDTH{left_q[WIDTH-1]}}, left_q}
                                  : {{WIDTH{1'b0}}, left_q};
        right_ext = (SIGNED != 0) ? {{WIDTH{right_q[WIDTH-1]}}, right_q}
                                  : {{WIDTH{1'b0}}, right_q};
        prod_full = left_ext * right_ext;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            left_q  <= '0;
            right_q <= '0;
            for (int i = 2; i <= STAGES; i++) begin
                prod_q[i] <= '0;
            end
        end else if (adv) begin
            valid_q[1] <= bus.in_valid;
            valid_q[STAGES:2] <= valid_q[STAGES-1:1];
            if (bus.in_valid) begin
                left_q  <= bus.left;
                right_q <= bus.right;
            end
            prod_q[2] <= prod_full;
            for (int i = 3; i <= STAGES; i++) begin
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    // Extra top bit keeps the rounding carry so it can raise ovf.
    always_comb begin
        sign_ext = (SIGNED != 0) & prod_q[STAGES][PW-1];
        rounded  = {sign_ext, prod_q[STAGES]} + ROUND_ADD;
        slice    = rounded[FRAC_WIDTH +: WIDTH];
        upper    = rounded[PW:FRAC_WIDTH+WIDTH];
        if (SIGNED != 0) begin
            ovf_c = (upper != {UW{slice[WIDTH-1]}});
        end else begin
            ovf_c = |upper;
        end
`ifdef FP_MULT_STREAM_SAT_EN
        if (ovf_c) begin
            if (SIGNED != 0) begin
                out_c = prod_q[STAGES][PW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                out_c = '1;
            end
        end else begin
            out_c = slice;
        end
`else
        out_c = slice;
`endif
    end

    assign unused_frac = ^rounded[FRAC_WIDTH-1:0];
    assign bus.out     = out_c;
    assign bus.ovf     = ovf_c;

endmodule

// File: tb/tb_fp_mult_stream.sv
// Scoreboard bench: unsigned/truncate, signed/truncate and unsigned/round
// instances see identical stimulus; a negedge monitor checks each head result.
module tb_fp_mult_stream;

    typedef struct packed {
        logic [31:0] val;
        logic        ovf;
    } exp_t;

`ifdef FP_MULT_STREAM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] left;
    logic [31:0] right;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    exp_t  sb [3][$];
    string dut_name [3] = '{"unsigned", "signed", "round"};

    logic        dut_valid  [3];
    logic        dut_iready [3];
    logic        dut_ovf    [3];
    logic [31:0] dut_out    [3];

    always #5 clk = ~clk;

    fp_mult_stream_if #(.WIDTH(32)) bus_u ();
    fp_mult_stream_if #(.WIDTH(32)) bus_s ();
    fp_mult_stream_if #(.WIDTH(32)) bus_r ();

    assign bus_u.in_valid = in_valid;
    assign bus_u.left = left;
    assign bus_u.right = right;
    assign bus_u.out_ready = out_ready;
    assign bus_s.in_valid = in_valid;
    assign bus_s.left = left;
    assign bus_s.right = right;
    assign bus_s.out_ready = out_ready;
    assign bus_r.in_valid = in_valid;
    assign bus_r.left = left;
    assign bus_r.right = right;
    assign bus_r.out_ready = out_ready;

    assign dut_valid[0] = bus_u.out_valid;
    assign dut_valid[1] = bus_s.out_valid;
    assign dut_valid[2] = bus_r.out_valid;
    assign dut_iready[0] = bus_u.in_ready;
    assign dut_iready[1] = bus_s.in_ready;
    assign dut_iready[2] = bus_r.in_ready;
    assign dut_ovf[0] = bus_u.ovf;
    assign dut_ovf[1] = bus_s.ovf;
    assign dut_ovf[2] = bus_r.ovf;
    assign dut_out[0] = bus_u.out;
    assign dut_out[1] = bus_s.out;
    assign dut_out[2] = bus_r.out;

    fp_mult_stream #(.SIGNED(0), .ROUND(0)) dut_u (.clk(clk), .reset(reset), .bus(bus_u));
    fp_mult_stream #(.SIGNED(1), .ROUND(0)) dut_s (.clk(clk), .reset(reset), .bus(bus_s));
    fp_mult_stream #(.SIGNED(0), .ROUND(1)) dut_r (.clk(clk), .reset(reset), .bus(bus_r));

    function automatic exp_t mk(input logic [31:0] v, input logic o);
        exp_t e;
        e.val = v;
        e.ovf = o;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic applyStimulus(input logic [31:0] l, input logic [31:0] r,
                                 input exp_t eu, input exp_t es, input exp_t er);
        logic ok;
        ok       = 1'b0;
        left     = l;
        right    = r;
        in_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            ok = dut_iready[0];
            @(posedge clk);
            if (ok) break;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL accept_timeout actual=in_ready_low expected=accept l=%h r=%h", l, r);
        end else begin
            sb[0].push_back(eu);
            sb[1].push_back(es);
            sb[2].push_back(er);
        end
        #1;
        in_valid = 1'b0;
        left     = 32'hDEADBEEF;
        right    = 32'hA5A5A5A5;
    endtask

    task automatic waitDrain(input string name);
        int left_over;
        for (int c = 0; c < 40; c++) begin
            if (sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0) break;
            @(posedge clk);
            #1;
        end
        left_over = sb[0].size() + sb[1].size() + sb[2].size();
        checkOutput(name, 32'(left_over), 32'd0);
    endtask

    // Head-of-queue check every cycle a result is presented, so held
    // results are also checked for stability while stalled.
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 3; d++) begin
                if (dut_valid[d]) begin
                    if (sb[d].size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL %s_unexpected actual out_valid=1 out=%h expected out_valid=0",
                                 dut_name[d], dut_out[d]);
                    end else begin
                        checkOutput($sformatf("%s_out", dut_name[d]), dut_out[d], sb[d][0].val);
                        checkOutput($sformatf("%s_ovf", dut_name[d]), 32'(dut_ovf[d]),
                                    32'(sb[d][0].ovf));
                        if (out_ready) void'(sb[d].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        left      = '0;
        right     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("%s_rst_valid", dut_name[d]), 32'(dut_valid[d]), 32'd0);
            checkOutput($sformatf("%s_rst_ready", dut_name[d]), 32'(dut_iready[d]), 32'd1);
            checkOutput($sformatf("%s_rst_out", dut_name[d]), dut_out[d], 32'd0);
            checkOutput($sformatf("%s_rst_ovf", dut_name[d]), 32'(dut_ovf[d]), 32'd0);
        end
        @(posedge clk);
        #1;

        // 1.5 * 2.0 = 3.0, with exact latency check
        applyStimulus(32'h00018000, 32'h00020000,
                      mk(32'h00030000, 0), mk(32'h00030000, 0), mk(32'h00030000, 0));
        @(negedge clk);
        checkOutput("latency_edge1", 32'(dut_valid[0]), 32'd0);
        @(negedge clk);
        checkOutput("latency_edge2", 32'(dut_valid[0]), 32'd0);
        @(negedge clk);
        checkOutput("latency_edge3", 32'(dut_valid[0]), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back directed vectors
        applyStimulus(32'hFFFE8000, 32'h00020000,
                      mk(SAT ? 32'hFFFFFFFF : 32'hFFFD0000, 1),
                      mk(32'hFFFD0000, 0),
                      mk(SAT ? 32'hFFFFFFFF : 32'hFFFD0000, 1));
        applyStimulus(32'h00000001, 32'h00008000,
                      mk(32'h00000000, 0), mk(32'h00000000, 0), mk(32'h00000001, 0));
        applyStimulus(32'h7FFF0000, 32'h00020000,
                      mk(32'hFFFE0000, 0),
                      mk(SAT ? 32'h7FFFFFFF : 32'hFFFE0000, 1),
                      mk(32'hFFFE0000, 0));
        // Product 0xFFFF_FFFF_8000: rounding carries out of the slice
        applyStimulus(32'h000925B7, 32'h1BFC8000,
                      mk(32'hFFFFFFFF, 0),
                      mk(SAT ? 32'h7FFFFFFF : 32'hFFFFFFFF, 1),
                      mk(SAT ? 32'hFFFFFFFF : 32'h00000000, 1));
        applyStimulus(32'hFFFF0000, 32'hFFFF0000,
                      mk(SAT ? 32'hFFFFFFFF : 32'h00010000, 1),
                      mk(32'h00010000, 0),
                      mk(SAT ? 32'hFFFFFFFF : 32'h00010000, 1));
        waitDrain("drain_directed");

        // Stream 1..6 with a five-cycle consumer stall
        fork
            begin
                for (int n = 1; n <= 6; n++) begin
                    applyStimulus(32'(n) << 16, 32'h00010000,
                                  mk(32'(n) << 16, 0), mk(32'(n) << 16, 0), mk(32'(n) << 16, 0));
                end
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                checkOutput("stream_ready_before_full", 32'(dut_iready[0]), 32'd1);
                @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                checkOutput("stall_in_ready", 32'(dut_iready[0]), 32'd0);
                checkOutput("stall_held_count", 32'(sb[0].size()), 32'd3);
                repeat (3) @(posedge clk);
                @(negedge clk);
                checkOutput("stall_in_ready_late", 32'(dut_iready[0]), 32'd0);
                checkOutput("stall_held_late", 32'(sb[0].size()), 32'd3);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        waitDrain("drain_stream");

        // Reset with two pairs in flight
        applyStimulus(32'h00018000, 32'h00020000,
                      mk(32'h00030000, 0), mk(32'h00030000, 0), mk(32'h00030000, 0));
        applyStimulus(32'h00000001, 32'h00008000,
                      mk(32'h00000000, 0), mk(32'h00000000, 0), mk(32'h00000001, 0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int d = 0; d < 3; d++) sb[d].delete();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput($sformatf("midrst_valid_%0d", c), 32'(dut_valid[0]), 32'd0);
        end
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("%s_midrst_out", dut_name[d]), dut_out[d], 32'd0);
            checkOutput($sformatf("%s_midrst_ready", dut_name[d]), 32'(dut_iready[d]), 32'd1);
        end
        @(posedge clk);
        #1;
        applyStimulus(32'hFFFE8000, 32'h00020000,
                      mk(SAT ? 32'hFFFFFFFF : 32'hFFFD0000, 1),
                      mk(32'hFFFD0000, 0),
                      mk(SAT ? 32'hFFFFFFFF : 32'hFFFD0000, 1));
        waitDrain("drain_after_reset");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
